// File: rtl/piece_sequencer.sv
// Tetromino sequencer: a Galois LFSR feeds an NES-style reroll drawer into a circular preview queue.
// Defining BAG7_EN swaps the draw rule for a 7-bag randomizer and exposes its used mask on Avalon address 1.
module piece_sequencer #(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] seed_in_i,
    input  logic        start_i,
    input  logic        piece_req_i,
    output logic        piece_valid_o,
    output logic [2:0]  piece_out_o,
    output logic [2:0]  preview_out_o,
    input  logic        avl_read_i,
    input  logic        avl_cs_i,
    input  logic [1:0]  avl_addr_i,
    output logic [31:0] avl_readdata_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [31:0] POLY = 32'h80200003;

    typedef enum logic [1:0] {IDLE, SEED, FILL, READY} state_t;

    state_t           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d, lfsrStep;
    logic [2:0]       queue_q [QDEPTH];
    logic [2:0]       queue_d [QDEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       last_q, last_d;
    logic [CNT_W-1:0] draws_q, draws_d;
    logic             valid_q, valid_d;
    logic [2:0]       piece_q, piece_d, preview_q, preview_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [2:0]       drawPiece;
    logic             doPop, doPush;

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef BAG7_EN
    logic [6:0] mask_q, mask_d;
    logic [2:0] bagBase, bagIdx;
    logic [3:0] bagSum;
    logic       bagFound;

    // Scan upward from the LFSR pick for the first id not yet dealt in this bag.
    always_comb begin
        bagBase   = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
        drawPiece = bagBase;
        bagFound  = 1'b0;
        bagSum    = '0;
        bagIdx    = '0;
        for (int k = 0; k < 7; k++) begin
            bagSum = {1'b0, bagBase} + 4'(k);
            bagIdx = (bagSum >= 4'd7) ? 3'(bagSum - 4'd7) : 3'(bagSum);
            if (!bagFound && !mask_q[bagIdx]) begin
                drawPiece = bagIdx;
                bagFound  = 1'b1;
            end
        end
    end
`else
    logic [3:0] rerollSum;
    logic [2:0] rerollPiece;

    always_comb begin
        rerollSum   = {1'b0, lfsr_q[10:8]} + {1'b0, last_q};
        rerollPiece = (rerollSum >= 4'd7) ? 3'(rerollSum - 4'd7) : 3'(rerollSum);
        drawPiece   = (lfsr_q[2:0] == 3'd7 || lfsr_q[2:0] == last_q) ? rerollPiece : lfsr_q[2:0];
    end
`endif

    always_comb begin
        lfsrStep = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        queue_d  = queue_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        last_d   = last_q;
        draws_d  = draws_q;
        doPop    = 1'b0;
        doPush   = 1'b0;
`ifdef BAG7_EN
        mask_d   = mask_q;
`endif
        // START wins over any pop in the same cycle; the draw counter survives a reseed.
        if (start_i) begin
            state_d = SEED;
            lfsr_d  = (seed_in_i == 32'h0) ? 32'h1 : seed_in_i;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            last_d  = 3'd0;
`ifdef BAG7_EN
            mask_d  = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                SEED: state_d = FILL;
                FILL, READY: begin
                    lfsr_d = lfsrStep;
                    doPop  = piece_req_i && valid_q;
                    doPush = (state_q == FILL) && (count_q != CW'(QDEPTH));
                    if (doPop) begin
                        head_d = incPtr(head_q);
                    end
                    if (doPush) begin
                        queue_d[tail_q] = drawPiece;
                        tail_d          = incPtr(tail_q);
                        last_d          = drawPiece;
                        draws_d         = draws_q + CNT_W'(1);
`ifdef BAG7_EN
                        mask_d = mask_q | (7'd1 << drawPiece);
                        if (mask_d == 7'h7F) begin
                            mask_d = '0;
                        end
`endif
                    end
                    if (doPush && !doPop) begin
                        count_d = count_q + CW'(1);
                    end else if (doPop && !doPush) begin
                        count_d = count_q - CW'(1);
                    end
                    state_d = (count_d == CW'(QDEPTH)) ? READY : FILL;
                end
                default: state_d = IDLE;
            endcase
        end

        valid_d   = (count_d != '0) && (state_d == FILL || state_d == READY);
        piece_d   = (count_d != '0) ? queue_d[head_d] : 3'd0;
        preview_d = (count_d >= CW'(2)) ? queue_d[incPtr(head_d)] : 3'd0;

        rdata_d = rdata_q;
        if (avl_read_i && avl_cs_i) begin
            unique case (avl_addr_i)
                2'd0: rdata_d = {valid_q, 25'b0, 3'(count_q), piece_q};
`ifdef BAG7_EN
                2'd1: rdata_d = {17'b0, mask_q, 5'b0, preview_q};
`else
                2'd1: rdata_d = {29'b0, preview_q};
`endif
                2'd2: rdata_d = 32'(draws_q);
                default: rdata_d = lfsr_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            lfsr_q    <= 32'h1;
            for (int i = 0; i < QDEPTH; i++) begin
                queue_q[i] <= 3'd0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            last_q    <= 3'd0;
            draws_q   <= '0;
            valid_q   <= 1'b0;
            piece_q   <= 3'd0;
            preview_q <= 3'd0;
            rdata_q   <= 32'h0;
`ifdef BAG7_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            queue_q   <= queue_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            last_q    <= last_d;
            draws_q   <= draws_d;
            valid_q   <= valid_d;
            piece_q   <= piece_d;
            preview_q <= preview_d;
            rdata_q   <= rdata_d;
`ifdef BAG7_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign piece_valid_o  = valid_q;
    assign piece_out_o    = piece_q;
    assign preview_out_o  = preview_q;
    assign avl_readdata_o = rdata_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer: a reference model of the LFSR and draw rule supplies expected pieces.
// Compiling with BAG7_EN defined switches the model and the group checks to the 7-bag rule.
module tb_piece_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, pieceReq, avlRead, avlCs;
    logic [31:0] seedIn;
    logic [1:0]  avlAddr;
    logic        pieceValid;
    logic [2:0]  pieceOut, previewOut;
    logic [31:0] avlReaddata;

    int          vectorCount = 0;
    int          missCount   = 0;

    logic [31:0] mLfsr;
    logic [2:0]  mLast;
    logic [6:0]  mMask;
    logic        mCase5;

    logic [31:0] rd, runSeed;
    logic [2:0]  p;
    logic [2:0]  d [4];
    logic [6:0]  seen;
    logic        found;

    piece_sequencer #(.QDEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk),
        .reset_i(reset),
        .seed_in_i(seedIn),
        .start_i(start),
        .piece_req_i(pieceReq),
        .piece_valid_o(pieceValid),
        .piece_out_o(pieceOut),
        .preview_out_o(previewOut),
        .avl_read_i(avlRead),
        .avl_cs_i(avlCs),
        .avl_addr_i(avlAddr),
        .avl_readdata_o(avlReaddata)
    );

    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic startV, input logic reqV, input logic [31:0] seedV);
        start    = startV;
        pieceReq = reqV;
        seedIn   = seedV;
        tick();
        start    = 1'b0;
    endtask

    task automatic resetPulse();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic avlReadReg(input logic [1:0] addr, output logic [31:0] data);
        avlRead = 1'b1;
        avlCs   = 1'b1;
        avlAddr = addr;
        tick();
        avlRead = 1'b0;
        avlCs   = 1'b0;
        data    = avlReaddata;
    endtask

    task automatic modelReset(input logic [31:0] seed);
        mLfsr = (seed == 32'h0) ? 32'h1 : seed;
        mLast = 3'd0;
        mMask = 7'd0;
    endtask

    // One draw from the current model LFSR, then advance the model by one step.
    task automatic modelDraw(output logic [2:0] piece);
        int r;
        logic [2:0] c;
        c      = mLfsr[2:0];
        mCase5 = (c == 3'd7) && (mLast == 3'd3) && (mLfsr[10:8] == 3'd5);
`ifdef BAG7_EN
        r = (c == 3'd7) ? 0 : int'(c);
        piece = 3'd0;
        for (int k = 6; k >= 0; k--) begin
            if (!mMask[(r + k) % 7]) piece = 3'((r + k) % 7);
        end
        mMask = mMask | (7'd1 << piece);
        if (mMask == 7'h7F) mMask = 7'd0;
`else
        if (c == 3'd7 || c == mLast) begin
            r     = (int'(mLfsr[10:8]) + int'(mLast)) % 7;
            piece = 3'(r);
        end else begin
            piece = c;
        end
`endif
        mLast = piece;
        mLfsr = (mLfsr >> 1) ^ (mLfsr[0] ? 32'h80200003 : 32'h0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pieceReq = 1'b0; seedIn = 32'h0;
        avlRead = 1'b0; avlCs = 1'b0; avlAddr = 2'd0;

        $display("[TB] reset state");
        resetPulse();
        checkOutput("rst_valid", 32'(pieceValid), 32'h0);
        checkOutput("rst_piece", 32'(pieceOut), 32'h0);
        checkOutput("rst_preview", 32'(previewOut), 32'h0);
        checkOutput("rst_readdata", avlReaddata, 32'h0);
        avlReadReg(2'd3, rd);
        checkOutput("rst_lfsr", rd, 32'h1);
        avlReadReg(2'd2, rd);
        checkOutput("rst_draws", rd, 32'h0);

        $display("[TB] zero seed start and latency");
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t1_valid_t1", 32'(pieceValid), 32'h0);
        avlReadReg(2'd3, rd);
        checkOutput("t1_lfsr_seeded", rd, 32'h1);
        checkOutput("t1_valid_t2", 32'(pieceValid), 32'h0);
        tick();
        checkOutput("t1_valid_t3", 32'(pieceValid), 32'h1);
        checkOutput("t1_piece0", 32'(pieceOut), 32'h1);

        $display("[TB] fill to full with DEADBEEF");
        resetPulse();
        modelReset(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) modelDraw(d[i]);
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);
        tick(); tick(); tick(); tick();
        avlReadReg(2'd0, rd);
        checkOutput("t2_status_t5", rd, {1'b1, 25'b0, 3'd3, d[0]});
        checkOutput("t2_valid", 32'(pieceValid), 32'h1);
        checkOutput("t2_head", 32'(pieceOut), 32'(d[0]));
        checkOutput("t2_preview", 32'(previewOut), 32'(d[1]));
`ifndef BAG7_EN
        checkOutput("t2_head_hand", 32'(pieceOut), 32'h6);
`endif
        avlReadReg(2'd0, rd);
        checkOutput("t2_status_t6", rd, {1'b1, 25'b0, 3'd4, d[0]});
        avlReadReg(2'd2, rd);
        checkOutput("t2_draws", rd, 32'h4);
        avlReadReg(2'd1, rd);
        checkOutput("t2_addr1", rd, {17'b0, mMask, 5'b0, d[1]});
        tick(); tick(); tick();
        avlReadReg(2'd2, rd);
        checkOutput("t2_draws_ready", rd, 32'h4);

        $display("[TB] START with simultaneous pop on a full queue");
        modelReset(32'hDEADBEEF);
        modelDraw(p);
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF);
        pieceReq = 1'b0;
        checkOutput("t4_valid_t1", 32'(pieceValid), 32'h0);
        checkOutput("t4_piece_t1", 32'(pieceOut), 32'h0);
        tick();
        checkOutput("t4_valid_t2", 32'(pieceValid), 32'h0);
        tick();
        checkOutput("t4_valid_t3", 32'(pieceValid), 32'h1);
        checkOutput("t4_piece_t3", 32'(pieceOut), 32'(p));
        tick(); tick(); tick();
        avlReadReg(2'd2, rd);
        checkOutput("t4_draws_kept", rd, 32'h8);

        $display("[TB] reset beats start");
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);
        reset = 1'b0;
        tick(); tick(); tick();
        checkOutput("rp_valid", 32'(pieceValid), 32'h0);
        avlReadReg(2'd3, rd);
        checkOutput("rp_lfsr", rd, 32'h1);

        runSeed = 32'hDEADBEEF;
`ifndef BAG7_EN
        found = 1'b0;
        for (int s = 0; s < 64 && !found; s++) begin
            modelReset(32'hDEADBEEF + 32'(s));
            for (int k = 0; k < 1000; k++) begin
                modelDraw(p);
                if (mCase5) found = 1'b1;
            end
            if (found) runSeed = 32'hDEADBEEF + 32'(s);
        end
`endif

        $display("[TB] continuous pop stream, seed %0h", runSeed);
        resetPulse();
        modelReset(runSeed);
        seen = 7'd0;
        applyStimulus(1'b1, 1'b1, runSeed);
        checkOutput("t3_valid_t1", 32'(pieceValid), 32'h0);
        tick();
        checkOutput("t3_valid_t2", 32'(pieceValid), 32'h0);
        for (int k = 0; k < 1000; k++) begin
            tick();
            modelDraw(p);
            checkOutput("t3_valid", 32'(pieceValid), 32'h1);
            checkOutput("t3_piece", 32'(pieceOut), 32'(p));
`ifdef BAG7_EN
            seen = seen | (7'd1 << pieceOut);
            if (k % 7 == 6) begin
                checkOutput("t6_bag_perm", 32'(seen), 32'h7F);
                seen = 7'd0;
            end
`else
            if (mCase5) checkOutput("t5_reroll_case", 32'(pieceOut), 32'h1);
`endif
        end
        pieceReq = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
